// File: rtl/branch_target_unit_if.sv
// Branch request channel: valid/ready handshake carrying the branch operands.
// The requester drives the master side, the branch unit is the slave.
interface branch_target_unit_if #(
  parameter int WIDTH  = 32,
  parameter int TYPE_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  pc_plus4;
  logic [WIDTH-1:0]  offset;
  logic [TYPE_W-1:0] br_type;
  logic [WIDTH-1:0]  rs_val;
  logic [WIDTH-1:0]  rt_val;

  modport master (
    output in_valid,
    output pc_plus4,
    output offset,
    output br_type,
    output rs_val,
    output rt_val,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  pc_plus4,
    input  offset,
    input  br_type,
    input  rs_val,
    input  rt_val,
    output in_ready
  );
endinterface

// File: rtl/branch_target_unit.sv
// MIPS branch target adder and condition evaluator with a one-cycle redirect.
// Define BRANCH_STATS_EN to add the taken_cnt/resolved_cnt counters.
module branch_target_unit #(
  parameter int WIDTH  = 32,
  parameter int TYPE_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  branch_target_unit_if.slave req,
  input  logic               flush,
  output logic               redirect,
  output logic [WIDTH-1:0]   target,
  output logic               resolved,
  output logic               taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]        taken_cnt,
  output logic [31:0]        resolved_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESOLVE
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  off;
    logic [TYPE_W-1:0] typ;
    logic [WIDTH-1:0]  rs;
    logic [WIDTH-1:0]  rt;
  } s1_t;

  localparam logic [TYPE_W-1:0] T_BEQ  = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] T_BNE  = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_BLEZ = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_BGTZ = TYPE_W'(3);
  localparam logic [TYPE_W-1:0] T_BLTZ = TYPE_W'(4);
  localparam logic [TYPE_W-1:0] T_BGEZ = TYPE_W'(5);

  state_t           state;
  s1_t              s1;
  logic [WIDTH-1:0] sum_q;
  logic             cond_q;
  logic             ready_q;

  logic [WIDTH-1:0] sum;
  logic             cond;
  logic             rs_neg;
  logic             rs_zero;
  logic             rs_eq_rt;

  assign req.in_ready = ready_q;

  // Carry out of the adder is dropped: targets wrap modulo 2^WIDTH.
  assign sum      = s1.pc + s1.off;
  assign rs_neg   = s1.rs[WIDTH-1];
  assign rs_zero  = (s1.rs == '0);
  assign rs_eq_rt = (s1.rs == s1.rt);

  always_comb begin
    cond = 1'b0;
    unique case (s1.typ)
      T_BEQ:   cond = rs_eq_rt;
      T_BNE:   cond = !rs_eq_rt;
      T_BLEZ:  cond = rs_neg || rs_zero;
      T_BGTZ:  cond = !rs_neg && !rs_zero;
      T_BLTZ:  cond = rs_neg;
      T_BGEZ:  cond = !rs_neg;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      s1       <= '0;
      sum_q    <= '0;
      cond_q   <= 1'b0;
      redirect <= 1'b0;
      resolved <= 1'b0;
      taken    <= 1'b0;
      target   <= '0;
`ifdef BRANCH_STATS_EN
      taken_cnt    <= '0;
      resolved_cnt <= '0;
`endif
    end else begin
      redirect <= 1'b0;
      resolved <= 1'b0;
      taken    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!flush && req.in_valid) begin
            s1.pc   <= req.pc_plus4;
            s1.off  <= req.offset;
            s1.typ  <= req.br_type;
            s1.rs   <= req.rs_val;
            s1.rt   <= req.rt_val;
            state   <= CALC;
            ready_q <= 1'b0;
          end
        end
        CALC: begin
          if (flush) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            sum_q  <= sum;
            cond_q <= cond;
            state  <= RESOLVE;
          end
        end
        RESOLVE: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          // A flush here kills the pulse before it reaches fetch.
          if (!flush) begin
            resolved <= 1'b1;
            taken    <= cond_q;
            if (cond_q) begin
              redirect <= 1'b1;
              target   <= sum_q;
            end
`ifdef BRANCH_STATS_EN
            resolved_cnt <= resolved_cnt + 32'd1;
            if (cond_q) taken_cnt <= taken_cnt + 32'd1;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit.
// Define BRANCH_STATS_EN to also check the counters.
module tb_branch_target_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        redirect;
  logic [31:0] target;
  logic        resolved;
  logic        taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] resolved_cnt;
`endif

  branch_target_unit_if #(.WIDTH(32), .TYPE_W(3)) bif ();

  branch_target_unit #(.WIDTH(32), .TYPE_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (bif),
    .flush    (flush),
    .redirect (redirect),
    .target   (target),
    .resolved (resolved),
    .taken    (taken)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt    (taken_cnt),
    .resolved_cnt (resolved_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tk;
    logic [31:0] tgt;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          pulses = 0;
  int          n_push = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] m_tgt = '0;
  int          m_taken = 0;
  int          m_res = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic logic model_cond(input logic [2:0] ty,
                                      input logic [31:0] rs,
                                      input logic [31:0] rt);
    case (ty)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) <= 0;
      3'd3:    return $signed(rs) > 0;
      3'd4:    return $signed(rs) < 0;
      3'd5:    return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (resolved === 1'b1) begin
      pulses++;
      if (q.size() == 0) begin
        check("spurious_resolve", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("taken", taken, mon_e.tk);
        check("redirect", redirect, mon_e.tk);
        check("target", target, mon_e.tgt);
        check("latency", cyc, mon_e.cyc);
      end
    end else if (redirect === 1'b1) begin
      check("redirect_no_resolve", 1, 0);
    end
  end

  task automatic drive(input logic [31:0] pc, input logic [31:0] off,
                       input logic [2:0] ty, input logic [31:0] rs,
                       input logic [31:0] rt);
    bif.pc_plus4 = pc;
    bif.offset   = off;
    bif.br_type  = ty;
    bif.rs_val   = rs;
    bif.rt_val   = rt;
  endtask

  task automatic expect_branch(input logic [31:0] pc, input logic [31:0] off,
                               input logic [2:0] ty, input logic [31:0] rs,
                               input logic [31:0] rt);
    exp_t e;
    logic c;
    c = model_cond(ty, rs, rt);
    if (c) begin
      m_tgt = pc + off;
      m_taken++;
    end
    m_res++;
    n_push++;
    e.tk  = c;
    e.tgt = m_tgt;
    e.cyc = cyc + 3;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] off,
                      input logic [2:0] ty, input logic [31:0] rs,
                      input logic [31:0] rt, input bit push);
    int g = 0;
    while (bif.in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (bif.in_ready !== 1'b1) begin
      check("ready_timeout", 0, 1);
      return;
    end
    drive(pc, off, ty, rs, rt);
    bif.in_valid = 1'b1;
    if (push) expect_branch(pc, off, ty, rs, rt);
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (q.size() != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic flush_case(input int lag);
    send(32'h00001000, 32'h40, 3'd0, 32'd9, 32'd9, 1'b0);
    repeat (lag) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_resolved", resolved, 0);
    check("flush_redirect", redirect, 0);
    check("flush_idle", bif.in_ready, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rs, rt;
    int acc;
    bif.in_valid = 1'b0;
    drive('0, '0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_ready", bif.in_ready, 1);
    check("rst_redirect", redirect, 0);
    check("rst_resolved", resolved, 0);
    check("rst_taken", taken, 0);
    check("rst_target", target, 0);
    reset = 1'b0;
    @(negedge clk);

    send(32'h00400004, 32'h00000010, 3'd0, 32'd5, 32'd5, 1'b1);
    send(32'h00400100, 32'h00000020, 3'd1, 32'd7, 32'd7, 1'b1);
    send(32'h00000008, 32'hFFFFFFF8, 3'd5, 32'd0, 32'd3, 1'b1);
    send(32'hFFFFFFFC, 32'h00000008, 3'd0, 32'd1, 32'd1, 1'b1);
    send(32'h00002000, 32'h00000100, 3'd4, 32'h80000000, 32'd0, 1'b1);
    send(32'h00003000, 32'h00000100, 3'd3, 32'h80000000, 32'd0, 1'b1);
    send(32'h00004000, 32'hFFFFFF00, 3'd2, 32'd0, 32'd5, 1'b1);
    send(32'h00005000, 32'h00000004, 3'd1, 32'd3, 32'd4, 1'b1);
    send(32'h00006000, 32'h00000008, 3'd3, 32'd1, 32'd0, 1'b1);
    send(32'h00007000, 32'h0000000C, 3'd2, 32'hFFFFFFFF, 32'd0, 1'b1);
    send(32'h00008000, 32'h00000010, 3'd2, 32'd1, 32'd0, 1'b1);
    send(32'h00009000, 32'h00000014, 3'd5, 32'hFFFFFFFF, 32'd0, 1'b1);
    send(32'h0000A000, 32'h00000018, 3'd4, 32'd0, 32'hFFFFFFFF, 1'b1);
    send(32'h0000B000, 32'h0000001C, 3'd6, 32'd2, 32'd2, 1'b1);
    send(32'h0000C000, 32'h00000020, 3'd7, 32'd2, 32'd2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
      send($urandom, $urandom, 3'($urandom_range(0, 7)), rs, rt, 1'b1);
    end
    drain();

    acc = 0;
    drive(32'h00010000, 32'h00000100, 3'd0, 32'd1, 32'd1);
    bif.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("ready_bp", bif.in_ready, (i % 3) == 0);
      if ((i % 3) == 0) begin
        expect_branch(32'h00010000, 32'h00000100, 3'd0, 32'd1, 32'd1);
        acc++;
      end
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    check("bp_accepts", acc, 2);
    drain();

    flush_case(1);
    flush_case(0);

    drive(32'h00020000, 32'h00000010, 3'd0, 32'd4, 32'd4);
    bif.in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    bif.in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_drop", bif.in_ready, 1);
    repeat (4) @(negedge clk);

    send(32'h00030000, 32'h00000010, 3'd0, 32'd4, 32'd4, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_ready", bif.in_ready, 1);
    check("rstmid_redirect", redirect, 0);
    check("rstmid_resolved", resolved, 0);
    check("rstmid_taken", taken, 0);
    check("rstmid_target", target, 0);
    m_tgt = '0;
    m_taken = 0;
    m_res = 0;
    repeat (4) @(negedge clk);

    send(32'h00040000, 32'h00000010, 3'd0, 32'd1, 32'd1, 1'b1);
    send(32'h00040000, 32'h00000020, 3'd1, 32'd1, 32'd2, 1'b1);
    send(32'h00040000, 32'h00000030, 3'd3, 32'd5, 32'd0, 1'b1);
    send(32'h00040000, 32'h00000040, 3'd0, 32'd1, 32'd2, 1'b1);
    send(32'h00040000, 32'h00000050, 3'd4, 32'd5, 32'd0, 1'b1);
    drain();
    flush_case(1);

`ifdef BRANCH_STATS_EN
    check("taken_cnt", taken_cnt, m_taken);
    check("resolved_cnt", resolved_cnt, m_res);
`endif
    check("pulse_total", pulses, n_push);
    check("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d want 0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Consumes the word offset produced by the shift-left-by-2 stage (sign-extended immediate << 2) and computes the MIPS branch target, target = pc_plus4 + offset.
- Evaluates the branch condition on the register operands and issues a one-cycle PC redirect to the fetch stage.
- Two-stage registered datapath with valid/ready handshake on the input side and a flush input from the hazard unit.

Parameters:
- WIDTH, 32, datapath width of PC, offset and operands.
- TYPE_W, 3, width of branch type code.

Ports:
- clk  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request carries a branch to evaluate.
- in_ready  output  1  unit can accept a request this cycle.
- pc_plus4  input  WIDTH  address of the instruction after the branch.
- offset  input  WIDTH  shifter output, already <<2 and sign-extended.
- br_type  input  TYPE_W  branch type: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6-7 reserved.
- rs_val  input  WIDTH  rs operand.
- rt_val  input  WIDTH  rt operand.
- flush  input  1  discard any in-flight branch.
- redirect  output  1  one-cycle pulse: branch taken, load target.
- target  output  WIDTH  branch target, valid when redirect=1.
- resolved  output  1  one-cycle pulse: branch finished, taken or not taken.
- taken  output  1  outcome, valid when resolved=1.

Behaviour:
- Reset values: in_ready=1, redirect=0, resolved=0, taken=0, target=0. FSM goes to IDLE.
- FSM states: IDLE, CALC, RESOLVE.
- IDLE: in_ready=1.
  - in_valid=1 captures pc_plus4, offset, br_type, rs_val, rt_val into stage-1 registers and moves to CALC.
  - in_valid=0 stays in IDLE.
- CALC: in_ready=0.
  - Computes sum = pc_plus4 + offset, modulo 2^WIDTH; wrap-around is silently discarded.
  - Computes cond: BEQ rs==rt; BNE rs!=rt; BLEZ signed rs<=0; BGTZ signed rs>0; BLTZ signed rs<0; BGEZ signed rs>=0; reserved codes give 0.
  - Registers sum and cond, then moves to RESOLVE.
- RESOLVE: in_ready=0.
  - Asserts resolved=1 and taken=cond for exactly one cycle.
  - If cond=1, also asserts redirect=1 with target=sum.
  - Returns to IDLE on the next edge.
- Latency: accept edge N, then resolved/redirect are high during the cycle after edge N+2. Throughput is one branch per 3 cycles.
- target holds its last value after redirect falls and is updated only on a taken resolve.
- in_ready is a pure function of state; it does not depend on in_valid.
- flush=1 in CALC or RESOLVE forces IDLE on the next edge. No redirect or resolved pulse is issued, even if RESOLVE was active that cycle; flush suppresses combinationally.
- flush=1 in IDLE blocks capture even if in_valid=1; the request is dropped.
- reset has priority over flush, and flush has priority over in_valid.
- reset mid-operation abandons the branch; all outputs return to reset values on the next edge.
- rt_val is ignored for the single-operand types.
- Signed compares treat bit WIDTH-1 as the sign bit.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds two outputs, taken_cnt[31:0] and resolved_cnt[31:0].
  - resolved_cnt increments on each resolved pulse; taken_cnt increments on each redirect.
  - Both reset to 0, wrap at 2^32, and are unaffected by flushed branches.
- Undefined: no counters, no extra ports; behaviour is otherwise identical.

Test Plan:
- Taken BEQ: pc_plus4=0x00400004, offset=0x00000010, rs=rt=5, type 0 -> redirect=1, target=0x00400014, taken=1, three cycles after accept, for one cycle.
- Not-taken BNE: rs=rt=7 -> resolved=1, taken=0, redirect=0, target keeps its previous value.
- Negative offset and wrap-around:
  - pc_plus4=0x00000008, offset=0xFFFFFFF8, BGEZ, rs=0 -> target=0x00000000, redirect=1.
  - pc_plus4=0xFFFFFFFC, offset=0x8 -> target=0x00000004.
- Signed compares: BLTZ with rs=0x80000000 -> taken=1. BGTZ with rs=0x80000000 -> taken=0. BLEZ with rs=0 -> taken=1.
- Flush and backpressure:
  - in_valid held high for 6 cycles -> in_ready=0 in CALC/RESOLVE, exactly two branches accepted.
  - flush asserted in RESOLVE -> no redirect/resolved, unit in IDLE next cycle.
  - reset asserted in CALC -> outputs zero, in_ready=1 next cycle.
- BRANCH_STATS_EN: 3 taken, 2 not-taken, 1 flushed branch -> taken_cnt=3, resolved_cnt=5.
